// File: rtl/row_tree_accumulator_if.sv
// Row/job bus between the row producer and row_tree_accumulator.
// Master side drives the job start and the row stream.
// Slave side returns row_ready, busy and the per-job result.
interface row_tree_accumulator_if #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 256,
  parameter int ACC_WIDTH     = 48,
  parameter int COUNT_WIDTH   = 16
);

  logic                                 start;
  logic [COUNT_WIDTH-1:0]               row_count;
  logic [NO_OF_UNITS*ELEMENT_WIDTH-1:0] row_data;
  logic                                 row_valid;
  logic                                 row_ready;
  logic                                 busy;
  logic [ACC_WIDTH-1:0]                 result;
  logic                                 result_valid;
  logic                                 overflow;

  // Row producer / job controller side
  modport master (
    output start,
    output row_count,
    output row_data,
    output row_valid,
    input  row_ready,
    input  busy,
    input  result,
    input  result_valid,
    input  overflow
  );

  // Accumulator side
  modport slave (
    input  start,
    input  row_count,
    input  row_data,
    input  row_valid,
    output row_ready,
    output busy,
    output result,
    output result_valid,
    output overflow
  );

endinterface

// File: rtl/row_tree_accumulator.sv
// Reduces each accepted row through a pipelined adder tree and sums the row totals over a job.
// Latency: result_valid LOG2N+2 cycles after the last accepted row; one row per clock in ACCEPT.
// Backpressure: row_ready is high only in ACCEPT and never depends on the tree; the tree never stalls.
// Optional feature macro ROW_TREE_ACC_SATURATE_EN: saturating accumulator with sticky overflow
// (undefined: accumulator wraps modulo 2^ACC_WIDTH and overflow is tied low).
module row_tree_accumulator #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 256,
  parameter int ACC_WIDTH     = 48,
  parameter int COUNT_WIDTH   = 16
) (
  input logic                   clk,
  input logic                   main_reset,
  row_tree_accumulator_if.slave bus
);

  localparam int LOG2N = $clog2(NO_OF_UNITS);
  localparam int EXT   = ACC_WIDTH - ELEMENT_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic                   row_ready_q;
  logic                   busy_q;
  logic [ACC_WIDTH-1:0]   result_q;
  logic                   result_valid_q;

  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   acc_d;

  // vld_q[0] marks the registered input row, vld_q[k] marks tree stage k
  logic [LOG2N:0]         vld_q;
  logic [ACC_WIDTH-1:0]   tree_sum;

  logic                   row_acc;
  logic                   job_start;

  assign row_acc   = bus.row_valid & row_ready_q;
  assign job_start = (state_q == IDLE) & bus.start;

  // Stage valid bits shift one step per clock; reset empties the whole pipeline
  always_ff @(posedge clk) begin
    if (main_reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LOG2N-1:0], row_acc};
    end
  end

  // Stage 0 holds the sign-extended row; stage k holds NO_OF_UNITS>>k partial sums.
  // Data registers carry no reset: only the valid bits qualify them.
  for (genvar k = 0; k <= LOG2N; k++) begin : g_stage
    localparam int W = NO_OF_UNITS >> k;
    logic [ACC_WIDTH-1:0] sum_q [W];

    if (k == 0) begin : g_load
      // Capture and sign-extend every element of an accepted row
      always_ff @(posedge clk) begin
        if (row_acc) begin
          for (int e = 0; e < W; e++) begin
            sum_q[e] <= {{EXT{bus.row_data[e*ELEMENT_WIDTH + ELEMENT_WIDTH - 1]}},
                         bus.row_data[e*ELEMENT_WIDTH +: ELEMENT_WIDTH]};
          end
        end
      end
    end else begin : g_add
      // Pairwise add of the previous stage whenever it holds a valid row
      always_ff @(posedge clk) begin
        if (vld_q[k-1]) begin
          for (int e = 0; e < W; e++) begin
            sum_q[e] <= g_stage[k-1].sum_q[2*e] + g_stage[k-1].sum_q[2*e+1];
          end
        end
      end
    end
  end

  assign tree_sum = g_stage[LOG2N].sum_q[0];

`ifdef ROW_TREE_ACC_SATURATE_EN
  logic                 overflow_q;
  logic                 overflow_d;
  logic [ACC_WIDTH:0]   sum_ext;

  // Add one guard bit; guard and sign disagreeing means the signed range was left
  always_comb begin
    sum_ext    = {acc_q[ACC_WIDTH-1], acc_q} + {tree_sum[ACC_WIDTH-1], tree_sum};
    acc_d      = acc_q;
    overflow_d = overflow_q;
    if (job_start) begin
      acc_d      = '0;
      overflow_d = 1'b0;
    end else if (vld_q[LOG2N]) begin
      if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
        acc_d      = sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        overflow_d = 1'b1;
      end else begin
        acc_d = sum_ext[ACC_WIDTH-1:0];
      end
    end
  end

  // Sticky overflow flag for the current job
  always_ff @(posedge clk) begin
    if (main_reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`else
  // Plain two's-complement accumulation, wrapping at ACC_WIDTH
  always_comb begin
    acc_d = acc_q;
    if (job_start) begin
      acc_d = '0;
    end else if (vld_q[LOG2N]) begin
      acc_d = acc_q + tree_sum;
    end
  end

  assign bus.overflow = 1'b0;
`endif

  // Job accumulator register
  always_ff @(posedge clk) begin
    if (main_reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Job control FSM. DRAIN leaves on the edge that performs the final accumulation
  // (only the last tree stage can still be valid), so DONE sees the complete sum.
  // busy stays high through the result_valid cycle and drops with it.
  always_ff @(posedge clk) begin
    if (main_reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      row_ready_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            cnt_q  <= bus.row_count;
            busy_q <= 1'b1;
            if (bus.row_count != '0) begin
              state_q     <= ACCEPT;
              row_ready_q <= 1'b1;
            end else begin
              state_q <= DONE;
            end
          end
        end
        ACCEPT: begin
          if (row_acc) begin
            cnt_q <= cnt_q - COUNT_WIDTH'(1);
            if (cnt_q == COUNT_WIDTH'(1)) begin
              state_q     <= DRAIN;
              row_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (vld_q[LOG2N-1:0] == '0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          result_q       <= acc_q;
          result_valid_q <= 1'b1;
          state_q        <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.row_ready    = row_ready_q;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;

endmodule
